// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: stopwatch state encoding and BCD digit limits
package stopwatch_pkg;
  typedef enum logic [1:0] {ST_PAUSED = 2'd0, ST_RUNNING = 2'd1, ST_ADJUST = 2'd2} state_t;
  localparam logic [3:0] DIG_MAX_ONES = 4'd9;
  localparam logic [3:0] DIG_MAX_TENS = 4'd5;
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one BCD digit counting 0..MAX on en, wrapping to 0 with carry; ports clk, clr (sync clear), en, q, carry
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = en && (q == MAX);
  always_ff @(posedge clk)
    q <= clr ? 4'd0 : carry ? 4'd0 : en ? q + 4'd1 : q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS stopwatch sequencer (run/pause/adjust, 1 Hz and 2 Hz dividers); in clk rst pause adj sel, out min_tens min_ones sec_tens sec_ones running tick_1hz tick_2hz blank; BLINK_EN enables blinking of the adjusted pair
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_1HZ = 100000000,
  parameter int CNT_2HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       tick_1hz,
  output logic       tick_2hz,
  output logic [3:0] blank
);
  localparam int W1 = $clog2(CNT_1HZ);
  localparam int W2 = $clog2(CNT_2HZ);
  logic [W1-1:0] c1;
  logic [W2-1:0] c2;
  state_t state, state_n;
  logic saved_run, run_inc, adj_inc;
  logic so_c, st_c, mo_c, mt_c, unused_mt_c;
  always_comb
    state_n = (adj && state != ST_ADJUST) ? ST_ADJUST :
              (state == ST_ADJUST) ? (adj ? ST_ADJUST : saved_run ? ST_RUNNING : ST_PAUSED) :
              pause ? (state == ST_RUNNING ? ST_PAUSED : ST_RUNNING) : state;
  // ticks are registered so they line up with the counter value CNT-1
  always_ff @(posedge clk) begin
    if (rst) begin
      c1 <= '0;
      c2 <= '0;
      tick_1hz <= 1'b0;
      tick_2hz <= 1'b0;
      state <= ST_PAUSED;
      running <= 1'b0;
      saved_run <= 1'b0;
    end else begin
      c1 <= (c1 == W1'(CNT_1HZ - 1)) ? '0 : c1 + W1'(1);
      c2 <= (c2 == W2'(CNT_2HZ - 1)) ? '0 : c2 + W2'(1);
      tick_1hz <= c1 == W1'(CNT_1HZ - 2);
      tick_2hz <= c2 == W2'(CNT_2HZ - 2);
      state <= state_n;
      running <= state_n == ST_RUNNING;
      if (adj && state != ST_ADJUST) saved_run <= state == ST_RUNNING;
    end
  end
  assign run_inc = state == ST_RUNNING && tick_1hz;
  assign adj_inc = state == ST_ADJUST && tick_2hz;
  // in adjust the seconds->minutes carry is cut so each pair wraps on its own
  bcd_digit #(.MAX(DIG_MAX_ONES)) u_so (.clk, .clr(rst), .en(run_inc | (adj_inc & sel)), .q(sec_ones), .carry(so_c));
  bcd_digit #(.MAX(DIG_MAX_TENS)) u_st (.clk, .clr(rst), .en(so_c), .q(sec_tens), .carry(st_c));
  bcd_digit #(.MAX(DIG_MAX_ONES)) u_mo (.clk, .clr(rst), .en((run_inc & st_c) | (adj_inc & ~sel)), .q(min_ones), .carry(mo_c));
  bcd_digit #(.MAX(DIG_MAX_TENS)) u_mt (.clk, .clr(rst), .en(mo_c), .q(min_tens), .carry(mt_c));
  assign unused_mt_c = mt_c;
`ifdef BLINK_EN
  logic blink;
  // blank is cleared for the cycle after an increment so the new value is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      blink <= 1'b0;
      blank <= 4'b0000;
    end else begin
      blink <= (state_n == ST_ADJUST) ? blink ^ tick_2hz : 1'b0;
      blank <= (state_n == ST_ADJUST && !adj_inc) ? (sel ? 4'b0011 : 4'b1100) & {4{blink ^ tick_2hz}} : 4'b0000;
    end
  end
`else
  assign blank = 4'b0000;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with a total-seconds behavioural model checked every cycle
module tb_stopwatch_ctrl;
  localparam int C1 = 4;
  localparam int C2 = 2;
  localparam int P = 0, R = 1, A = 2;
  logic clk = 1'b0, rst = 1'b1, pause = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic running, tick_1hz, tick_2hz;
  int compared = 0, mismatched = 0;
  bit mv = 1'b0;
  int m_secs = 0, m_state = P, m_saved = 0, m_cyc = 0;
  bit m_t1 = 1'b0, m_t2 = 1'b0;
  int mm, ss;

  stopwatch_ctrl #(.CNT_1HZ(C1), .CNT_2HZ(C2)) dut (
    .clk(clk), .rst(rst), .pause(pause), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .blank(blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mv = 1'b1;
      m_secs = 0;
      m_state = P;
      m_saved = 0;
      m_cyc = 0;
    end else begin
      if (m_state == R && m_t1) m_secs = (m_secs + 1) % 3600;
      if (m_state == A && m_t2)
        m_secs = sel ? (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60
                     : ((m_secs / 60 + 1) % 60) * 60 + m_secs % 60;
      if (adj && m_state != A) begin
        m_saved = (m_state == R) ? 1 : 0;
        m_state = A;
      end else if (m_state == A) begin
        if (!adj) m_state = m_saved ? R : P;
      end else if (pause) m_state = (m_state == R) ? P : R;
      m_cyc++;
    end
    m_t1 = (m_cyc % C1) == C1 - 1;
    m_t2 = (m_cyc % C2) == C2 - 1;
  end

  always @(negedge clk) if (mv) begin
    mm = m_secs / 60;
    ss = m_secs % 60;
    compared++;
    if (min_tens != 4'(mm / 10) || min_ones != 4'(mm % 10) || sec_tens != 4'(ss / 10) ||
        sec_ones != 4'(ss % 10) || running != (m_state == R) || tick_1hz != m_t1 ||
        tick_2hz != m_t2 || (m_state != A && blank != 4'b0000)) begin
      mismatched++;
      $display("FAIL cycle t=%0t: got %0d%0d:%0d%0d run=%b t1=%b t2=%b blank=%b, expected %0d%0d:%0d%0d run=%b t1=%b t2=%b",
               $time, min_tens, min_ones, sec_tens, sec_ones, running, tick_1hz, tick_2hz, blank,
               mm / 10, mm % 10, ss / 10, ss % 10, m_state == R, m_t1, m_t2);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int shown();
    return min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones;
  endfunction

  task automatic wait_t1();
    int n = 0;
    while (!tick_1hz && n < 12) begin
      cyc(1);
      n++;
    end
    if (!tick_1hz) begin
      compared++;
      mismatched++;
      $display("FAIL wait_t1: no tick_1hz within 12 cycles");
    end
  endtask

  task automatic wait_t2();
    int n = 0;
    while (!tick_2hz && n < 12) begin
      cyc(1);
      n++;
    end
    if (!tick_2hz) begin
      compared++;
      mismatched++;
      $display("FAIL wait_t2: no tick_2hz within 12 cycles");
    end
  endtask

  task automatic adj_ticks(int n);
    repeat (n) begin
      wait_t2();
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(20);
    check("idle_digits", shown(), 0);
    check("idle_running", running, 0);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("run_started", running, 1);
    repeat (10) begin
      wait_t1();
      cyc(1);
    end
    check("ten_ticks", shown(), 10);
    wait_t1();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("tick_with_pause", shown(), 11);
    check("paused_after_tick", running, 0);
    cyc(8);
    check("paused_hold", shown(), 11);
    adj = 1'b1;
    sel = 1'b0;
    cyc(1);
    adj_ticks(59);
    sel = 1'b1;
    adj_ticks(47);
    check("preload_5958", shown(), 5958);
    adj = 1'b0;
    cyc(1);
    check("exit_to_paused", running, 0);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    wait_t1();
    cyc(1);
    check("run_5959", shown(), 5959);
    wait_t1();
    cyc(1);
    check("wrap_0000", shown(), 0);
    repeat (5) begin
      wait_t1();
      cyc(1);
    end
    check("run_0005", shown(), 5);
    adj = 1'b1;
    sel = 1'b1;
    cyc(1);
    check("adjust_not_running", running, 0);
    adj_ticks(6);
    check("adj_sec_0011", shown(), 11);
    adj = 1'b0;
    cyc(1);
    check("resume_running", running, 1);
    check("resume_value", shown(), 11);
    wait_t1();
    cyc(1);
    check("resume_0012", shown(), 12);
    adj = 1'b1;
    sel = 1'b0;
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    check("pause_on_adj_rise", running, 0);
    adj_ticks(58);
    check("adj_min_5812", shown(), 5812);
    adj_ticks(1);
    check("adj_min_5912", shown(), 5912);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    adj_ticks(1);
    check("adj_min_wrap", shown(), 12);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    adj_ticks(1);
    check("adj_min_0112", shown(), 112);
    check("adj_pause_ignored", running, 0);
    adj = 1'b0;
    cyc(1);
    check("exit_saved_run", running, 1);
    wait_t1();
    cyc(1);
    check("run_0113", shown(), 113);
    adj = 1'b1;
    sel = 1'b0;
    cyc(1);
    adj_ticks(11);
    sel = 1'b1;
    adj_ticks(21);
    adj = 1'b0;
    cyc(1);
    check("preload_1234", shown(), 1234);
    check("running_1234", running, 1);
    rst = 1'b1;
    cyc(1);
    check("rst_digits", shown(), 0);
    check("rst_running", running, 0);
    check("rst_blank", blank, 0);
    check("rst_tick1", tick_1hz, 0);
    rst = 1'b0;
    cyc(10);
    check("post_rst_digits", shown(), 0);
    check("post_rst_running", running, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencer for the MM:SS stopwatch digit chain: run, pause and adjust modes.
- Generates the 1 Hz count tick and the 2 Hz adjust tick from the system clock.
- Steps four cascaded BCD digits (min_tens, min_ones, sec_tens, sec_ones) and presents registered digit values to the seven-segment display driver.
- Inputs come from the already-debounced button/switch front end.

Parameters:
CNT_1HZ, 100000000, clk cycles per 1 Hz tick (>=2)
CNT_2HZ, 50000000, clk cycles per 2 Hz tick (>=2)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
pause  in  1  single-cycle pulse (debounced); toggles run/pause
adj  in  1  level; 1 = adjust mode
sel  in  1  level; adjust target: 0 = minutes, 1 = seconds
min_tens  out  4  BCD 0-5
min_ones  out  4  BCD 0-9
sec_tens  out  4  BCD 0-5
sec_ones  out  4  BCD 0-9
running  out  1  1 while state == RUNNING
tick_1hz  out  1  one-cycle pulse every CNT_1HZ cycles
tick_2hz  out  1  one-cycle pulse every CNT_2HZ cycles
blank  out  4  per-digit blank mask {mt,mo,st,so}; only with BLINK_EN, else tied 0

Behaviour:
- Reset (sync, active-high, all outputs registered):
  - all digits 0; state PAUSED; running 0; ticks 0; blank 0.
  - divider counters 0; saved-run flag 0.
  - rst asserted mid-operation overrides everything on that edge.
- Dividers: free-running, never gated by state.
  - tick_1hz is high for exactly one cycle when its counter reaches CNT_1HZ-1; counter then wraps to 0.
  - First tick_1hz is on cycle CNT_1HZ-1 after rst deasserts (cycle 0 = first cycle with rst low). tick_2hz follows the same rule with CNT_2HZ.
- States: PAUSED, RUNNING, ADJUST. Transitions are evaluated on the registered inputs each edge, in priority order:
  - adj==1 and state!=ADJUST -> ADJUST; saved_run <= (state==RUNNING).
  - ADJUST and adj==0 -> RUNNING if saved_run, else PAUSED.
  - PAUSED and pause -> RUNNING.
  - RUNNING and pause -> PAUSED.
  - A pause pulse while in ADJUST, or in the same cycle that adj first rises, is ignored.
- Counting (RUNNING only): count enable = (state==RUNNING) && tick_1hz, using the current-cycle state.
  - sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens.
  - 59:59 -> 00:00 wraps with no overflow flag.
  - tick_1hz and pause in the same RUNNING cycle: the increment happens and the state becomes PAUSED.
- Adjust (ADJUST only): on each tick_2hz, increment the selected field by 1.
  - sel=1: seconds 00..59, wrapping 59->00 with no carry into minutes.
  - sel=0: minutes 00..59, wrapping 59->00.
  - tick_1hz has no effect in ADJUST.
  - A change of sel takes effect on the next tick_2hz.
- Digits update on the edge following the enabling cycle: one cycle of latency from the tick to the visible digit.

Optional Feature:
BLINK_EN
- Defined: in ADJUST, the selected pair blinks. blank bits for that pair toggle on every tick_2hz, and are forced to 0 on the cycle a tick_2hz increments the field, so the new value is shown. blank is 0 outside ADJUST and on exit from ADJUST.
- Undefined: blank is constant 4'b0000 and no toggle register is instantiated.

Decomposition:
- Package stopwatch_pkg:
  - state typedef/localparams ST_PAUSED=0, ST_RUNNING=1, ST_ADJUST=2.
  - constants DIG_MAX_ONES=9, DIG_MAX_TENS=5.
- One sub-module, bcd_digit: 4-bit BCD digit with inputs en and clr, parameter MAX, output carry = en && (q==MAX), and wrap to 0.
  - Instantiate four times. Adjust-mode increments reuse the same en path, with the carry gated off at the pair boundary.

Test Plan (CNT_1HZ=4, CNT_2HZ=2):
- Reset then idle 20 cycles -> digits 00:00, running 0; tick_1hz pulses at cycles 3,7,11...
- pause pulse, run 10 ticks -> 00:10; inject pause on the same cycle as the 11th tick -> 00:11 shown, running 0, no further change.
- Preload to 59:58 via adjust, run 2 ticks -> 59:59, then 00:00.
- From RUNNING at 00:05, raise adj with sel=1 for 6 tick_2hz -> 00:11, counting frozen; drop adj -> state RUNNING, resumes 00:12 on the next tick.
- ADJUST with sel=0 at minutes 58, 3 tick_2hz -> 59, 00, 01; seconds unchanged; pause pulses during ADJUST ignored.
- Assert rst mid-count at 12:34 while RUNNING -> next edge 00:00, PAUSED; with BLINK_EN, blank==0 after reset.
